membus_responder: RTL

Single-ported memory responder for the core's `ibus` and `dbus` request interfaces; the target side of the fetch and memory stages. It arbitrates the two buses, with `dbus` having fixed priority. It serves one transaction at a time from an internal 64-bit-word RAM after a programmable latency. It returns `addr_ok`/`data_ok` so the pipeline's stall logic can be exercised without the external simulation memory.

---
 rtl/membus_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/membus_responder.sv
// Single-ported 64-bit RAM responder for the ibus/dbus request interfaces.
// dbus has fixed priority; one transaction at a time after LATENCY cycles.
package membus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module membus_responder
  import membus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 65536,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        own_d_q, own_d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  strb_q, strb_d;
  logic [63:0] wdat_q, wdat_d;
  ibus_resp_t  iresp_q, iresp_d;
  dbus_resp_t  dresp_q, dresp_d;
  logic        load_resp;

  logic [63:0] mem_q [MEM_WORDS];

  logic [63:0]   lk_addr;
  logic [63:0]   off;
  logic          in_rng;
  logic [AW-1:0] idx;
  logic [63:0]   rword;
  logic          mem_we;
  logic          unused_bits;

  // In IDLE the decode looks at the request being accepted so that a
  // LATENCY==1 response can be loaded on the accept edge.
  always_comb begin
    lk_addr = addr_q;
    if (state_q == S_IDLE) begin
      lk_addr = dreq.valid ? dreq.addr : ireq.addr;
    end
  end

  assign off    = lk_addr - BASE_ADDR;
  assign in_rng = (lk_addr >= BASE_ADDR) &&
                  (off[63:3] < 61'(MEM_WORDS));
  assign idx    = off[AW+2:3];
  assign rword  = in_rng ? mem_q[idx] : '0;
  assign mem_we = (state_q == S_RESP) && !reset &&
                  own_d_q && (strb_q != '0) && in_rng;

  assign unused_bits = ^{off[2:0], dreq.size};

  always_comb begin
    state_d   = state_q;
    own_d_d   = own_d_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    strb_d    = strb_q;
    wdat_d    = wdat_q;
    iresp_d   = '0;
    dresp_d   = '0;
    load_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dreq.valid || ireq.valid) begin
          own_d_d = dreq.valid;
          addr_d  = lk_addr;
          strb_d  = dreq.valid ? dreq.strobe : 8'h00;
          wdat_d  = dreq.data;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d   = S_RESP;
            load_resp = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = S_RESP;
          load_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_resp) begin
      if (own_d_d) begin
        dresp_d.addr_ok = 1'b1;
        dresp_d.data_ok = 1'b1;
        dresp_d.data    = rword;
      end else begin
        iresp_d.addr_ok = 1'b1;
        iresp_d.data_ok = 1'b1;
        iresp_d.data    = lk_addr[2] ? rword[63:32]
                                     : rword[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      own_d_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdat_q  <= '0;
      iresp_q <= '0;
      dresp_q <= '0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdat_q  <= wdat_d;
      iresp_q <= iresp_d;
      dresp_q <= dresp_d;
    end
  end

  // Writes commit on RESP exit, after the same transaction's read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (strb_q[k]) begin
          mem_q[idx][8*k +: 8] <= wdat_q[8*k +: 8];
        end
      end
    end
  end

  assign iresp = iresp_q;
  assign dresp = dresp_q;

endmodule
